sram_bus_arbiter_n: RTL and testbench

//  N-master to 1-slave arbiter for the internal cache-line SRAM bus, generalising the fixed 4-port interconnect.

---
 rtl/sram_bus_arbiter_n_pkg.sv | 42 ++++
 rtl/sram_bus_arbiter_n_rr.sv | 42 ++++
 rtl/sram_bus_arbiter_n.sv | 211 +++++++++++++++++++++
 tb/tb_sram_bus_arbiter_n.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_n_pkg.sv
// Shared definitions for the cache-line SRAM bus arbiter: request type codes,
// channel FSM state encodings and default-width bus structs used by cache_top.
package sram_bus_arbiter_n_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 256;
  localparam int SB_TYPE_W = 6;
  localparam int SB_STRB_W = 16;

  // Request type/size encodings carried on the *_type fields
  localparam logic [SB_TYPE_W-1:0] SB_TYPE_LINE     = 6'h00;
  localparam logic [SB_TYPE_W-1:0] SB_TYPE_WORD     = 6'h01;
  localparam logic [SB_TYPE_W-1:0] SB_TYPE_HALF     = 6'h02;
  localparam logic [SB_TYPE_W-1:0] SB_TYPE_BYTE     = 6'h03;
  localparam logic [SB_TYPE_W-1:0] SB_TYPE_UNCACHED = 6'h20;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } r_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } w_state_t;

  typedef struct packed {
    logic                 req;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_TYPE_W-1:0] typ;
  } sb_rd_req_t;

  typedef struct packed {
    logic                 req;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_TYPE_W-1:0] typ;
    logic [SB_STRB_W-1:0] strb;
  } sb_wr_req_t;

endpackage

// File: rtl/sram_bus_arbiter_n_rr.sv
// Request arbiter: round-robin starting at ptr, or fixed priority (index 0
// highest) when ARB_RR is 0. Produces a one-hot grant, its index and the
// pointer value to use after this grant.
module rr_arbiter
  import sram_bus_arbiter_n_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int ARB_RR  = 1,
  parameter int PTR_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_MST-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic [PTR_W-1:0]   next_ptr
);

  logic hit;
  int   cand;

  // Scan candidates in priority order and pick the first requester
  always_comb begin
    gnt      = '0;
    idx      = '0;
    next_ptr = ptr;
    hit      = 1'b0;
    cand     = 0;
    for (int k = 0; k < NUM_MST; k++) begin
      cand = (ARB_RR != 0) ? ((int'(ptr) + k) % NUM_MST) : k;
      if (en && !hit && req[cand]) begin
        hit       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
    if (hit) begin
      next_ptr = (int'(idx) == NUM_MST - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter_n.sv
// N-master to single-bridge arbiter for the cache-line SRAM bus. Read and
// write channels have independent FSMs and arbiters; reads to a line that
// the in-flight write targets are held back until that write is accepted.
module sram_bus_arbiter_n
  import sram_bus_arbiter_n_pkg::*;
#(
  parameter int NUM_MST  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 256,
  parameter int TYPE_W   = 6,
  parameter int STRB_W   = 16,
  parameter int LINE_OFF = 5,
  parameter int ARB_RR   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MST-1:0]         mst_r_req,
  input  logic [NUM_MST*ADDR_W-1:0]  mst_r_addr,
  input  logic [NUM_MST*TYPE_W-1:0]  mst_r_type,
  output logic [NUM_MST-1:0]         mst_r_rdy,
  output logic [DATA_W-1:0]          mst_re_data,
  output logic [NUM_MST-1:0]         mst_re_valid,
  input  logic [NUM_MST-1:0]         mst_w_req,
  input  logic [NUM_MST*ADDR_W-1:0]  mst_w_addr,
  input  logic [NUM_MST*DATA_W-1:0]  mst_w_data,
  input  logic [NUM_MST*TYPE_W-1:0]  mst_w_type,
  input  logic [NUM_MST*STRB_W-1:0]  mst_w_strb,
  output logic [NUM_MST-1:0]         mst_w_rdy,
  output logic                       slv_r_req,
  output logic [ADDR_W-1:0]          slv_r_addr,
  output logic [TYPE_W-1:0]          slv_r_type,
  input  logic                       slv_r_rdy,
  input  logic [DATA_W-1:0]          slv_re_data,
  input  logic                       slv_re_valid,
  output logic                       slv_w_req,
  output logic [ADDR_W-1:0]          slv_w_addr,
  output logic [DATA_W-1:0]          slv_w_data,
  output logic [TYPE_W-1:0]          slv_w_type,
  output logic [STRB_W-1:0]          slv_w_strb,
  input  logic                       slv_w_rdy
);

  localparam int PTR_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int TAG_W = ADDR_W - LINE_OFF;

  r_state_t            r_state_q, r_state_d;
  logic [NUM_MST-1:0]  r_gnt_q, r_gnt_d;
  logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
  logic [TYPE_W-1:0]   r_type_q, r_type_d;
  logic [PTR_W-1:0]    r_ptr_q, r_ptr_d;

  w_state_t            w_state_q, w_state_d;
  logic [NUM_MST-1:0]  w_gnt_q, w_gnt_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [TYPE_W-1:0]   w_type_q, w_type_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;
  logic [PTR_W-1:0]    w_ptr_q, w_ptr_d;

  logic [NUM_MST-1:0]  r_elig;
  logic [NUM_MST-1:0]  r_arb_gnt, w_arb_gnt;
  logic [PTR_W-1:0]    r_arb_idx, w_arb_idx;
  logic [PTR_W-1:0]    r_arb_next, w_arb_next;

  // A read is held back while the busy write targets the same cache line
  always_comb begin
    r_elig = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      r_elig[i] = mst_r_req[i] &&
                  !((w_state_q == W_BUSY) &&
                    (mst_r_addr[i*ADDR_W+LINE_OFF +: TAG_W] == w_addr_q[ADDR_W-1:LINE_OFF]));
    end
  end

  rr_arbiter #(.NUM_MST(NUM_MST), .ARB_RR(ARB_RR), .PTR_W(PTR_W)) u_rd_arb (
    .req      (r_elig),
    .ptr      (r_ptr_q),
    .en       (r_state_q == R_IDLE),
    .gnt      (r_arb_gnt),
    .idx      (r_arb_idx),
    .next_ptr (r_arb_next)
  );

  rr_arbiter #(.NUM_MST(NUM_MST), .ARB_RR(ARB_RR), .PTR_W(PTR_W)) u_wr_arb (
    .req      (mst_w_req),
    .ptr      (w_ptr_q),
    .en       (w_state_q == W_IDLE),
    .gnt      (w_arb_gnt),
    .idx      (w_arb_idx),
    .next_ptr (w_arb_next)
  );

  assign slv_r_addr = r_addr_q;
  assign slv_r_type = r_type_q;
  assign slv_w_addr = w_addr_q;
  assign slv_w_data = w_data_q;
  assign slv_w_type = w_type_q;
  assign slv_w_strb = w_strb_q;

  // Read channel: grant and latch, hold request to bridge, forward response
  always_comb begin
    r_state_d    = r_state_q;
    r_gnt_d      = r_gnt_q;
    r_addr_d     = r_addr_q;
    r_type_d     = r_type_q;
    r_ptr_d      = r_ptr_q;
    slv_r_req    = 1'b0;
    mst_r_rdy    = '0;
    mst_re_valid = '0;
    mst_re_data  = '0;
    case (r_state_q)
      R_IDLE: begin
        if (|r_arb_gnt) begin
          r_state_d = R_REQ;
          r_gnt_d   = r_arb_gnt;
          r_addr_d  = mst_r_addr[r_arb_idx*ADDR_W +: ADDR_W];
          r_type_d  = mst_r_type[r_arb_idx*TYPE_W +: TYPE_W];
          if (ARB_RR != 0) r_ptr_d = r_arb_next;
        end
      end
      R_REQ: begin
        slv_r_req = 1'b1;
        if (slv_r_rdy) begin
          mst_r_rdy = r_gnt_q;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (slv_re_valid) begin
          mst_re_valid = r_gnt_q;
          mst_re_data  = slv_re_data;
          r_state_d    = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write channel: grant and latch payload, hold request until bridge accepts
  always_comb begin
    w_state_d = w_state_q;
    w_gnt_d   = w_gnt_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_type_d  = w_type_q;
    w_strb_d  = w_strb_q;
    w_ptr_d   = w_ptr_q;
    slv_w_req = 1'b0;
    mst_w_rdy = '0;
    case (w_state_q)
      W_IDLE: begin
        if (|w_arb_gnt) begin
          w_state_d = W_BUSY;
          w_gnt_d   = w_arb_gnt;
          w_addr_d  = mst_w_addr[w_arb_idx*ADDR_W +: ADDR_W];
          w_data_d  = mst_w_data[w_arb_idx*DATA_W +: DATA_W];
          w_type_d  = mst_w_type[w_arb_idx*TYPE_W +: TYPE_W];
          w_strb_d  = mst_w_strb[w_arb_idx*STRB_W +: STRB_W];
          if (ARB_RR != 0) w_ptr_d = w_arb_next;
        end
      end
      W_BUSY: begin
        slv_w_req = 1'b1;
        if (slv_w_rdy) begin
          mst_w_rdy = w_gnt_q;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= '0;
      r_addr_q  <= '0;
      r_type_q  <= '0;
      r_ptr_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_gnt_q   <= r_gnt_d;
      r_addr_q  <= r_addr_d;
      r_type_q  <= r_type_d;
      r_ptr_q   <= r_ptr_d;
    end
  end

  // Write channel state register
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_gnt_q   <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_type_q  <= '0;
      w_strb_q  <= '0;
      w_ptr_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_gnt_q   <= w_gnt_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_type_q  <= w_type_d;
      w_strb_q  <= w_strb_d;
      w_ptr_q   <= w_ptr_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter_n.sv
// Testbench for sram_bus_arbiter_n: directed scenarios plus randomized
// concurrent read/write traffic checked against a grant-order model.
module tb_sram_bus_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TW = 6;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Main DUT (4 masters, round-robin)
  logic [N-1:0]    m_r_req, m_r_rdy, m_re_valid, m_w_req, m_w_rdy;
  logic [N*AW-1:0] m_r_addr, m_w_addr;
  logic [N*TW-1:0] m_r_type, m_w_type;
  logic [N*DW-1:0] m_w_data;
  logic [N*SW-1:0] m_w_strb;
  logic [DW-1:0]   m_re_data, s_re_data, s_w_data;
  logic            s_r_req, s_r_rdy, s_re_valid, s_w_req, s_w_rdy;
  logic [AW-1:0]   s_r_addr, s_w_addr;
  logic [TW-1:0]   s_r_type, s_w_type;
  logic [SW-1:0]   s_w_strb;

  sram_bus_arbiter_n #(.NUM_MST(N), .ARB_RR(1)) dut (
    .clk(clk), .rst(rst),
    .mst_r_req(m_r_req), .mst_r_addr(m_r_addr), .mst_r_type(m_r_type), .mst_r_rdy(m_r_rdy),
    .mst_re_data(m_re_data), .mst_re_valid(m_re_valid),
    .mst_w_req(m_w_req), .mst_w_addr(m_w_addr), .mst_w_data(m_w_data), .mst_w_type(m_w_type),
    .mst_w_strb(m_w_strb), .mst_w_rdy(m_w_rdy),
    .slv_r_req(s_r_req), .slv_r_addr(s_r_addr), .slv_r_type(s_r_type), .slv_r_rdy(s_r_rdy),
    .slv_re_data(s_re_data), .slv_re_valid(s_re_valid),
    .slv_w_req(s_w_req), .slv_w_addr(s_w_addr), .slv_w_data(s_w_data), .slv_w_type(s_w_type),
    .slv_w_strb(s_w_strb), .slv_w_rdy(s_w_rdy)
  );

  // Fixed-priority DUT (reads only exercised)
  logic [N-1:0]    f_r_req, f_r_rdy, f_re_valid, f_w_rdy;
  logic [N*AW-1:0] f_r_addr;
  logic [DW-1:0]   f_re_data, f_s_re_data, f_s_w_data;
  logic            f_s_r_req, f_s_r_rdy, f_s_re_valid, f_s_w_req;
  logic [AW-1:0]   f_s_r_addr, f_s_w_addr;
  logic [TW-1:0]   f_s_r_type, f_s_w_type;
  logic [SW-1:0]   f_s_w_strb;

  sram_bus_arbiter_n #(.NUM_MST(N), .ARB_RR(0)) dut_fix (
    .clk(clk), .rst(rst),
    .mst_r_req(f_r_req), .mst_r_addr(f_r_addr), .mst_r_type('0), .mst_r_rdy(f_r_rdy),
    .mst_re_data(f_re_data), .mst_re_valid(f_re_valid),
    .mst_w_req('0), .mst_w_addr('0), .mst_w_data('0), .mst_w_type('0),
    .mst_w_strb('0), .mst_w_rdy(f_w_rdy),
    .slv_r_req(f_s_r_req), .slv_r_addr(f_s_r_addr), .slv_r_type(f_s_r_type), .slv_r_rdy(f_s_r_rdy),
    .slv_re_data(f_s_re_data), .slv_re_valid(f_s_re_valid),
    .slv_w_req(f_s_w_req), .slv_w_addr(f_s_w_addr), .slv_w_data(f_s_w_data), .slv_w_type(f_s_w_type),
    .slv_w_strb(f_s_w_strb), .slv_w_rdy(1'b0)
  );

  // Three-master round-robin DUT for pointer wrap
  logic [2:0]      t_r_req, t_r_rdy, t_re_valid, t_w_rdy;
  logic [3*AW-1:0] t_r_addr;
  logic [DW-1:0]   t_re_data, t_s_re_data, t_s_w_data;
  logic            t_s_r_req, t_s_r_rdy, t_s_re_valid, t_s_w_req;
  logic [AW-1:0]   t_s_r_addr, t_s_w_addr;
  logic [TW-1:0]   t_s_r_type, t_s_w_type;
  logic [SW-1:0]   t_s_w_strb;

  sram_bus_arbiter_n #(.NUM_MST(3), .ARB_RR(1)) dut3 (
    .clk(clk), .rst(rst),
    .mst_r_req(t_r_req), .mst_r_addr(t_r_addr), .mst_r_type('0), .mst_r_rdy(t_r_rdy),
    .mst_re_data(t_re_data), .mst_re_valid(t_re_valid),
    .mst_w_req('0), .mst_w_addr('0), .mst_w_data('0), .mst_w_type('0),
    .mst_w_strb('0), .mst_w_rdy(t_w_rdy),
    .slv_r_req(t_s_r_req), .slv_r_addr(t_s_r_addr), .slv_r_type(t_s_r_type), .slv_r_rdy(t_s_r_rdy),
    .slv_re_data(t_s_re_data), .slv_re_valid(t_s_re_valid),
    .slv_w_req(t_s_w_req), .slv_w_addr(t_s_w_addr), .slv_w_data(t_s_w_data), .slv_w_type(t_s_w_type),
    .slv_w_strb(t_s_w_strb), .slv_w_rdy(1'b0)
  );

  // The bridge model never accepts a read and returns data in the same cycle
  always @(posedge clk) begin
    if (!rst && s_r_req && s_r_rdy && s_re_valid)
      $error("[TB] bridge protocol: rdy and re_valid together");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    m_r_req = '0; m_r_addr = '0; m_r_type = '0; m_w_req = '0; m_w_addr = '0;
    m_w_data = '0; m_w_type = '0; m_w_strb = '0;
    s_r_rdy = 1'b0; s_re_valid = 1'b0; s_re_data = '0; s_w_rdy = 1'b0;
    f_r_req = '0; f_r_addr = '0; f_s_r_rdy = 1'b0; f_s_re_valid = 1'b0; f_s_re_data = '0;
    t_r_req = '0; t_r_addr = '0; t_s_r_rdy = 1'b0; t_s_re_valid = 1'b0; t_s_re_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_sr(output bit ok);
    for (int k = 0; k < 20; k++) begin
      if (s_r_req) break;
      tick();
    end
    ok = s_r_req;
  endtask

  task automatic wait_sw(output bit ok);
    for (int k = 0; k < 20; k++) begin
      if (s_w_req) break;
      tick();
    end
    ok = s_w_req;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    reset_all();
    rst = 1'b1;
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom | 32'h1;
    m_r_req = '1; m_w_req = '1; s_re_data = d; s_re_valid = 1'b1;
    tick(); tick();
    n_checks++; if (s_r_req !== 1'b0) $display("[TB] FAIL rst_slv_r_req: got %0h exp 0", s_r_req); else n_pass++;
    n_checks++; if (s_w_req !== 1'b0) $display("[TB] FAIL rst_slv_w_req: got %0h exp 0", s_w_req); else n_pass++;
    n_checks++; if (m_r_rdy !== 4'h0) $display("[TB] FAIL rst_mst_r_rdy: got %0h exp 0", m_r_rdy); else n_pass++;
    n_checks++; if (m_w_rdy !== 4'h0) $display("[TB] FAIL rst_mst_w_rdy: got %0h exp 0", m_w_rdy); else n_pass++;
    n_checks++; if (m_re_valid !== 4'h0) $display("[TB] FAIL rst_re_valid: got %0h exp 0", m_re_valid); else n_pass++;
    n_checks++; if (m_re_data !== '0) $display("[TB] FAIL rst_re_data: got %0h exp 0", m_re_data); else n_pass++;
    n_checks++; if (s_r_addr !== '0) $display("[TB] FAIL rst_slv_r_addr: got %0h exp 0", s_r_addr); else n_pass++;
    n_checks++; if (s_w_data !== '0) $display("[TB] FAIL rst_slv_w_data: got %0h exp 0", s_w_data); else n_pass++;
    m_r_req = '0; m_w_req = '0; s_re_valid = 1'b0; s_re_data = '0;
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (s_r_req !== 1'b0) $display("[TB] FAIL idle_no_req: got %0h exp 0", s_r_req); else n_pass++;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] d;
    reset_all();
    m_r_req[2] = 1'b1; m_r_addr[2*AW +: AW] = 32'h8000_0040; m_r_type[2*TW +: TW] = 6'h05;
    #1;
    n_checks++; if (s_r_req !== 1'b0) $display("[TB] FAIL rd_req_early: got %0h exp 0", s_r_req); else n_pass++;
    tick();
    n_checks++; if (s_r_req !== 1'b1) $display("[TB] FAIL rd_req_rise: got %0h exp 1", s_r_req); else n_pass++;
    n_checks++; if (s_r_addr !== 32'h8000_0040) $display("[TB] FAIL rd_addr: got %0h exp 80000040", s_r_addr); else n_pass++;
    n_checks++; if (s_r_type !== 6'h05) $display("[TB] FAIL rd_type: got %0h exp 5", s_r_type); else n_pass++;
    s_r_rdy = 1'b1; #1;
    n_checks++; if (m_r_rdy !== 4'b0100) $display("[TB] FAIL rd_rdy_m2: got %0h exp 4", m_r_rdy); else n_pass++;
    tick();
    s_r_rdy = 1'b0; m_r_req = '0; #1;
    n_checks++; if (s_r_req !== 1'b0) $display("[TB] FAIL rd_wait_req_low: got %0h exp 0", s_r_req); else n_pass++;
    d = {8{32'hA5A5_A5A5}};
    s_re_data = d; s_re_valid = 1'b1; #1;
    n_checks++; if (m_re_valid !== 4'b0100) $display("[TB] FAIL rd_valid_m2: got %0h exp 4", m_re_valid); else n_pass++;
    n_checks++; if (m_re_data !== d) $display("[TB] FAIL rd_data: got %0h exp %0h", m_re_data, d); else n_pass++;
    tick();
    s_re_valid = 1'b0; s_re_data = '0;
  endtask

  task automatic test_rr_fairness();
    int  ptr;
    int  exp_m;
    bit  ok;
    logic [N-1:0] oh;
    reset_all();
    for (int i = 0; i < N; i++) m_r_addr[i*AW +: AW] = 32'h3000_0000 + 32'(i) * 32'h100;
    m_r_req = '1;
    ptr = 0;
    for (int g = 0; g < 5; g++) begin
      exp_m = ptr;
      oh = '0; oh[exp_m] = 1'b1;
      wait_sr(ok);
      n_checks++; if (!ok) $display("[TB] FAIL rr_timeout: got 0 exp 1"); else n_pass++;
      n_checks++;
      if (s_r_addr !== 32'h3000_0000 + 32'(exp_m) * 32'h100)
        $display("[TB] FAIL rr_addr_%0d: got %0h exp master %0d", g, s_r_addr, exp_m);
      else n_pass++;
      tick(); tick();
      s_r_rdy = 1'b1; #1;
      n_checks++; if (m_r_rdy !== oh) $display("[TB] FAIL rr_grant_%0d: got %0h exp %0h", g, m_r_rdy, oh); else n_pass++;
      tick();
      s_r_rdy = 1'b0; s_re_valid = 1'b1; #1;
      n_checks++; if (m_re_valid !== oh) $display("[TB] FAIL rr_valid_%0d: got %0h exp %0h", g, m_re_valid, oh); else n_pass++;
      tick();
      s_re_valid = 1'b0;
      ptr = (exp_m + 1) % N;
    end
    m_r_req = '0;
  endtask

  task automatic test_fixed_priority();
    bit ok;
    reset_all();
    for (int i = 0; i < N; i++) f_r_addr[i*AW +: AW] = 32'h5000_0000 + 32'(i) * 32'h40;
    f_r_req = '1;
    for (int g = 0; g < 3; g++) begin
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (f_s_r_req) begin ok = 1'b1; break; end
        tick();
      end
      n_checks++; if (!ok) $display("[TB] FAIL fix_timeout: got 0 exp 1"); else n_pass++;
      f_s_r_rdy = 1'b1; #1;
      n_checks++; if (f_r_rdy !== 4'b0001) $display("[TB] FAIL fix_grant_%0d: got %0h exp 1", g, f_r_rdy); else n_pass++;
      tick();
      f_s_r_rdy = 1'b0; f_s_re_valid = 1'b1; #1;
      n_checks++; if (f_re_valid !== 4'b0001) $display("[TB] FAIL fix_valid_%0d: got %0h exp 1", g, f_re_valid); else n_pass++;
      tick();
      f_s_re_valid = 1'b0;
    end
    f_r_req = '0;
  endtask

  task automatic test_line_hazard();
    reset_all();
    m_w_req[1] = 1'b1; m_w_addr[1*AW +: AW] = 32'h8000_1000;
    m_w_data[1*DW +: DW] = {8{$urandom}}; m_w_strb[1*SW +: SW] = 16'hFFFF;
    tick();
    n_checks++; if (s_w_req !== 1'b1) $display("[TB] FAIL hz_w_req: got %0h exp 1", s_w_req); else n_pass++;
    m_r_req[0] = 1'b1; m_r_addr[0 +: AW] = 32'h8000_1010;
    tick(); tick(); tick();
    n_checks++; if (s_r_req !== 1'b0) $display("[TB] FAIL hz_blocked: got %0h exp 0", s_r_req); else n_pass++;
    m_r_req[3] = 1'b1; m_r_addr[3*AW +: AW] = 32'h8000_2000;
    tick();
    n_checks++; if (s_r_req !== 1'b1) $display("[TB] FAIL hz_other_req: got %0h exp 1", s_r_req); else n_pass++;
    n_checks++; if (s_r_addr !== 32'h8000_2000) $display("[TB] FAIL hz_other_addr: got %0h exp 80002000", s_r_addr); else n_pass++;
    s_r_rdy = 1'b1; #1;
    n_checks++; if (m_r_rdy !== 4'b1000) $display("[TB] FAIL hz_other_rdy: got %0h exp 8", m_r_rdy); else n_pass++;
    tick();
    s_r_rdy = 1'b0; m_r_req[3] = 1'b0; s_re_valid = 1'b1;
    tick();
    s_re_valid = 1'b0;
    tick();
    n_checks++; if (s_r_req !== 1'b0) $display("[TB] FAIL hz_still_blocked: got %0h exp 0", s_r_req); else n_pass++;
    s_w_rdy = 1'b1; #1;
    n_checks++; if (m_w_rdy !== 4'b0010) $display("[TB] FAIL hz_w_rdy: got %0h exp 2", m_w_rdy); else n_pass++;
    tick();
    s_w_rdy = 1'b0; m_w_req = '0; #1;
    n_checks++; if (s_r_req !== 1'b0) $display("[TB] FAIL hz_release_lat: got %0h exp 0", s_r_req); else n_pass++;
    tick();
    n_checks++; if (s_r_req !== 1'b1) $display("[TB] FAIL hz_released: got %0h exp 1", s_r_req); else n_pass++;
    n_checks++; if (s_r_addr !== 32'h8000_1010) $display("[TB] FAIL hz_rel_addr: got %0h exp 80001010", s_r_addr); else n_pass++;
    s_r_rdy = 1'b1; tick();
    s_r_rdy = 1'b0; m_r_req = '0; s_re_valid = 1'b1; tick();
    s_re_valid = 1'b0;
  endtask

  task automatic test_concurrent();
    reset_all();
    m_r_req[0] = 1'b1; m_r_addr[0 +: AW] = 32'h1000_0000;
    m_w_req[3] = 1'b1; m_w_addr[3*AW +: AW] = 32'h2000_0040;
    tick();
    n_checks++; if (s_r_req !== 1'b1) $display("[TB] FAIL cc_r_req: got %0h exp 1", s_r_req); else n_pass++;
    n_checks++; if (s_w_req !== 1'b1) $display("[TB] FAIL cc_w_req: got %0h exp 1", s_w_req); else n_pass++;
    s_w_rdy = 1'b1; #1;
    n_checks++; if (m_w_rdy !== 4'b1000) $display("[TB] FAIL cc_w_rdy: got %0h exp 8", m_w_rdy); else n_pass++;
    n_checks++; if (m_r_rdy !== 4'b0000) $display("[TB] FAIL cc_r_rdy_quiet: got %0h exp 0", m_r_rdy); else n_pass++;
    tick();
    s_w_rdy = 1'b0; m_w_req = '0; s_r_rdy = 1'b1; #1;
    n_checks++; if (m_r_rdy !== 4'b0001) $display("[TB] FAIL cc_r_rdy: got %0h exp 1", m_r_rdy); else n_pass++;
    n_checks++; if (m_w_rdy !== 4'b0000) $display("[TB] FAIL cc_w_rdy_quiet: got %0h exp 0", m_w_rdy); else n_pass++;
    tick();
    s_r_rdy = 1'b0; m_r_req = '0; s_re_valid = 1'b1; #1;
    n_checks++; if (m_re_valid !== 4'b0001) $display("[TB] FAIL cc_valid: got %0h exp 1", m_re_valid); else n_pass++;
    tick();
    s_re_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    reset_all();
    m_r_req[1] = 1'b1; m_r_addr[1*AW +: AW] = 32'h4000_0080;
    tick();
    s_r_rdy = 1'b1; tick();
    s_r_rdy = 1'b0; m_r_req = '0;
    rst = 1'b1; tick();
    rst = 1'b0;
    n_checks++; if (s_r_req !== 1'b0) $display("[TB] FAIL mr_req: got %0h exp 0", s_r_req); else n_pass++;
    n_checks++; if (s_r_addr !== '0) $display("[TB] FAIL mr_addr: got %0h exp 0", s_r_addr); else n_pass++;
    s_re_data = {8{32'hDEAD_BEEF}}; s_re_valid = 1'b1; #1;
    n_checks++; if (m_re_valid !== 4'h0) $display("[TB] FAIL mr_late_valid: got %0h exp 0", m_re_valid); else n_pass++;
    n_checks++; if (m_re_data !== '0) $display("[TB] FAIL mr_late_data: got %0h exp 0", m_re_data); else n_pass++;
    tick();
    s_re_valid = 1'b0; s_re_data = '0;
    m_r_req[2] = 1'b1; m_r_addr[2*AW +: AW] = 32'h4000_0100;
    tick();
    n_checks++; if (s_r_req !== 1'b1) $display("[TB] FAIL mr_next_req: got %0h exp 1", s_r_req); else n_pass++;
    n_checks++; if (s_r_addr !== 32'h4000_0100) $display("[TB] FAIL mr_next_addr: got %0h exp 40000100", s_r_addr); else n_pass++;
    s_r_rdy = 1'b1; #1;
    n_checks++; if (m_r_rdy !== 4'b0100) $display("[TB] FAIL mr_next_rdy: got %0h exp 4", m_r_rdy); else n_pass++;
    tick();
    s_r_rdy = 1'b0; m_r_req = '0; s_re_valid = 1'b1; tick();
    s_re_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int ptr;
    int w;
    bit ok;
    logic [2:0] pend;
    logic [2:0] oh;
    reset_all();
    for (int i = 0; i < 3; i++) t_r_addr[i*AW +: AW] = 32'h6000_0000 + 32'(i) * 32'h80;
    ptr = 0;
    for (int step = 0; step < 3; step++) begin
      if (step == 0) t_r_req = 3'b010;
      if (step == 1) t_r_req = 3'b101;
      pend = t_r_req;
      w = -1;
      for (int k = 0; k < 3; k++) if (w < 0 && pend[(ptr + k) % 3]) w = (ptr + k) % 3;
      oh = '0; oh[w] = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (t_s_r_req) begin ok = 1'b1; break; end
        tick();
      end
      n_checks++; if (!ok) $display("[TB] FAIL wrap_timeout_%0d: got 0 exp 1", step); else n_pass++;
      t_s_r_rdy = 1'b1; #1;
      n_checks++; if (t_r_rdy !== oh) $display("[TB] FAIL wrap_grant_%0d: got %0h exp %0h", step, t_r_rdy, oh); else n_pass++;
      tick();
      t_s_r_rdy = 1'b0; t_r_req = t_r_req & ~oh; t_s_re_valid = 1'b1; #1;
      n_checks++; if (t_re_valid !== oh) $display("[TB] FAIL wrap_valid_%0d: got %0h exp %0h", step, t_re_valid, oh); else n_pass++;
      tick();
      t_s_re_valid = 1'b0;
      ptr = (w + 1) % 3;
    end
  endtask

  task automatic rand_reads(input int rounds);
    int ptr = 0;
    int w;
    bit ok;
    logic [N-1:0]  pend, oh;
    logic [AW-1:0] addrs [N];
    logic [TW-1:0] types [N];
    logic [DW-1:0] d;
    for (int r = 0; r < rounds; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        addrs[i] = {4'h1, 28'($urandom)};
        types[i] = 6'($urandom);
        m_r_addr[i*AW +: AW] = addrs[i];
        m_r_type[i*TW +: TW] = types[i];
      end
      m_r_req = pend;
      while (pend != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
        oh = '0; oh[w] = 1'b1;
        wait_sr(ok);
        n_checks++; if (!ok) $display("[TB] FAIL rnd_r_timeout: got 0 exp 1"); else n_pass++;
        n_checks++; if (s_r_addr !== addrs[w]) $display("[TB] FAIL rnd_r_addr: got %0h exp %0h", s_r_addr, addrs[w]); else n_pass++;
        n_checks++; if (s_r_type !== types[w]) $display("[TB] FAIL rnd_r_type: got %0h exp %0h", s_r_type, types[w]); else n_pass++;
        repeat ($urandom_range(0, 2)) tick();
        s_r_rdy = 1'b1; #1;
        n_checks++; if (m_r_rdy !== oh) $display("[TB] FAIL rnd_r_rdy: got %0h exp %0h", m_r_rdy, oh); else n_pass++;
        tick();
        s_r_rdy = 1'b0; m_r_req[w] = 1'b0; pend[w] = 1'b0;
        ptr = (w + 1) % N;
        repeat ($urandom_range(0, 2)) tick();
        for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
        s_re_data = d; s_re_valid = 1'b1; #1;
        n_checks++; if (m_re_valid !== oh) $display("[TB] FAIL rnd_r_valid: got %0h exp %0h", m_re_valid, oh); else n_pass++;
        n_checks++; if (m_re_data !== d) $display("[TB] FAIL rnd_r_data: got %0h exp %0h", m_re_data, d); else n_pass++;
        tick();
        s_re_valid = 1'b0;
      end
    end
  endtask

  task automatic rand_writes(input int rounds);
    int ptr = 0;
    int w;
    bit ok;
    logic [N-1:0]  pend, oh;
    logic [AW-1:0] addrs [N];
    logic [DW-1:0] datas [N];
    logic [SW-1:0] strbs [N];
    for (int r = 0; r < rounds; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        addrs[i] = {4'h2, 28'($urandom)};
        for (int j = 0; j < 8; j++) datas[i][j*32 +: 32] = $urandom;
        strbs[i] = 16'($urandom);
        m_w_addr[i*AW +: AW] = addrs[i];
        m_w_data[i*DW +: DW] = datas[i];
        m_w_strb[i*SW +: SW] = strbs[i];
      end
      m_w_req = pend;
      while (pend != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
        oh = '0; oh[w] = 1'b1;
        wait_sw(ok);
        n_checks++; if (!ok) $display("[TB] FAIL rnd_w_timeout: got 0 exp 1"); else n_pass++;
        n_checks++; if (s_w_addr !== addrs[w]) $display("[TB] FAIL rnd_w_addr: got %0h exp %0h", s_w_addr, addrs[w]); else n_pass++;
        n_checks++; if (s_w_data !== datas[w]) $display("[TB] FAIL rnd_w_data: got %0h exp %0h", s_w_data, datas[w]); else n_pass++;
        n_checks++; if (s_w_strb !== strbs[w]) $display("[TB] FAIL rnd_w_strb: got %0h exp %0h", s_w_strb, strbs[w]); else n_pass++;
        repeat ($urandom_range(0, 3)) tick();
        s_w_rdy = 1'b1; #1;
        n_checks++; if (m_w_rdy !== oh) $display("[TB] FAIL rnd_w_rdy: got %0h exp %0h", m_w_rdy, oh); else n_pass++;
        tick();
        s_w_rdy = 1'b0; m_w_req[w] = 1'b0; pend[w] = 1'b0;
        ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic test_random();
    reset_all();
    fork
      rand_reads(6);
      rand_writes(6);
    join
  endtask

  // Guard against a stuck simulation
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_fixed_priority();
    test_line_hazard();
    test_concurrent();
    test_reset_mid_read();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
